// File: rtl/max_n5_arbiter_if.sv
// max_n5_arbiter_if: requester-side bundle of the max_n5 arbiter.
// Requests and vectors flow in; grants and results flow back.
interface max_n5_arbiter_if #(
  parameter int BW   = 8,
  parameter int NREQ = 4,
  parameter int IDW  = 2
) ();
  logic                   en;
  logic [NREQ-1:0]        req;
  logic [NREQ*5*BW-1:0]   req_data;
  logic [NREQ-1:0]        gnt;
  logic [NREQ-1:0]        rsp_valid;
  logic [BW-1:0]          rsp_data;
  logic [IDW-1:0]         rsp_id;

  modport master (
    output en, req, req_data,
    input  gnt, rsp_valid, rsp_data, rsp_id
  );

  modport slave (
    input  en, req, req_data,
    output gnt, rsp_valid, rsp_data, rsp_id
  );
endinterface

// File: rtl/max_n5_arbiter.sv
// max_n5_arbiter: round-robin sharing of one max_n5 pipeline
// among NREQ requesters, with ID tags tracked to the result.
module max_n5_arbiter #(
  parameter int BW   = 8,
  parameter int NREQ = 4,
  parameter int LAT  = 3,
  parameter int IDW  = 2
) (
  input  logic            clk,
  input  logic            rst,
  max_n5_arbiter_if.slave rq,
  output logic            mx_den_in,
  output logic [BW-1:0]   mx_data0,
  output logic [BW-1:0]   mx_data1,
  output logic [BW-1:0]   mx_data2,
  output logic [BW-1:0]   mx_data3,
  output logic [BW-1:0]   mx_data4,
  input  logic [BW-1:0]   mx_data_max,
  input  logic            mx_den_out,
  output logic [2:0]      in_flight,
  output logic            err
);

  localparam int FW = $clog2(LAT + 1);

  logic [IDW-1:0]    ptr;
  logic [FW-1:0]     flush;
  logic [IDW-1:0]    tag_id;
  logic [LAT-1:0]    tv;
  logic [IDW-1:0]    tid [LAT];
  logic [5*BW-1:0]   vecs [NREQ];
  logic [5*BW-1:0]   gvec;
  logic              gv;
  logic [IDW-1:0]    gid;
  logic [IDW:0]      sum;
  logic [IDW-1:0]    idx;
  logic              live;
  logic              t_v;
  logic [IDW-1:0]    t_id;
  logic              hit;
  logic              mism;

  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      vecs[i] = rq.req_data[i*5*BW +: 5*BW];
    end
  end

  assign live = (flush == '0);

  // first requester at or after ptr, wrapping at NREQ
  always_comb begin
    gv  = 1'b0;
    gid = '0;
    sum = '0;
    idx = '0;
    if (rq.en && live) begin
      for (int k = 0; k < NREQ; k++) begin
        sum = {1'b0, ptr} + (IDW+1)'(k);
        if (sum >= (IDW+1)'(NREQ)) begin
          sum = sum - (IDW+1)'(NREQ);
        end
        idx = sum[IDW-1:0];
        if (!gv && rq.req[idx]) begin
          gv  = 1'b1;
          gid = idx;
        end
      end
    end
  end

  assign gvec = vecs[gid];
  assign t_v  = tv[LAT-1];
  assign t_id = tid[LAT-1];
  assign hit  = live && mx_den_out && t_v;
  assign mism = live && (mx_den_out != t_v);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr       <= '0;
      flush     <= FW'(LAT);
      rq.gnt    <= '0;
      mx_den_in <= 1'b0;
      mx_data0  <= '0;
      mx_data1  <= '0;
      mx_data2  <= '0;
      mx_data3  <= '0;
      mx_data4  <= '0;
      tag_id    <= '0;
    end else begin
      if (!live) begin
        flush <= flush - 1'b1;
      end
      rq.gnt    <= gv ? (NREQ'(1) << gid) : '0;
      mx_den_in <= gv;
      if (gv) begin
        ptr      <= (int'(gid) == NREQ - 1) ? '0
                                            : gid + 1'b1;
        tag_id   <= gid;
        mx_data0 <= gvec[0*BW +: BW];
        mx_data1 <= gvec[1*BW +: BW];
        mx_data2 <= gvec[2*BW +: BW];
        mx_data3 <= gvec[3*BW +: BW];
        mx_data4 <= gvec[4*BW +: BW];
      end
    end
  end

  // tag shift aligned so stage LAT-1 matches mx_den_out
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tv <= '0;
      for (int k = 0; k < LAT; k++) begin
        tid[k] <= '0;
      end
    end else begin
      tv[0]  <= mx_den_in;
      tid[0] <= tag_id;
      for (int k = 1; k < LAT; k++) begin
        tv[k]  <= tv[k-1];
        tid[k] <= tid[k-1];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rq.rsp_valid <= '0;
      rq.rsp_data  <= '0;
      rq.rsp_id    <= '0;
      in_flight    <= '0;
      err          <= 1'b0;
    end else begin
      rq.rsp_valid <= hit ? (NREQ'(1) << t_id) : '0;
      if (hit) begin
        rq.rsp_data <= mx_data_max;
        rq.rsp_id   <= t_id;
      end
      if (mism) begin
        err <= 1'b1;
      end
      // a tag leaving the pipe retires its op even if dropped
      unique case ({gv, t_v})
        2'b10:   in_flight <= in_flight + 3'd1;
        2'b01:   in_flight <= in_flight - 3'd1;
        default: in_flight <= in_flight;
      endcase
    end
  end

endmodule

// File: tb/tb_max_n5_arbiter.sv
// tb_max_n5_arbiter: random and directed stimulus checked
// every cycle against a queue-based model of the arbiter.
module tb_max_n5_arbiter;
  localparam int BW   = 8;
  localparam int NREQ = 4;
  localparam int LAT  = 3;
  localparam int IDW  = 2;
  localparam int DEP  = 64;

  typedef logic [5*BW-1:0] vec_t;
  typedef struct {
    int id;
    int mx;
    int due;
  } tag_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  max_n5_arbiter_if #(
    .BW(BW), .NREQ(NREQ), .IDW(IDW)
  ) rq ();

  logic          mx_den_in;
  logic [BW-1:0] mx_data0, mx_data1, mx_data2;
  logic [BW-1:0] mx_data3, mx_data4;
  logic [BW-1:0] mx_data_max = '0;
  logic          mx_den_out = 1'b0;
  logic [2:0]    in_flight;
  logic          err;

  max_n5_arbiter #(
    .BW(BW), .NREQ(NREQ), .LAT(LAT), .IDW(IDW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .rq(rq),
    .mx_den_in(mx_den_in),
    .mx_data0(mx_data0),
    .mx_data1(mx_data1),
    .mx_data2(mx_data2),
    .mx_data3(mx_data3),
    .mx_data4(mx_data4),
    .mx_data_max(mx_data_max),
    .mx_den_out(mx_den_out),
    .in_flight(in_flight),
    .err(err)
  );

  int total = 0;
  int bad   = 0;

  vec_t qbuf [NREQ][DEP];
  int   hd [NREQ];
  int   tl [NREQ];

  logic          mxv [LAT];
  logic [BW-1:0] mxm [LAT];
  logic          spur = 1'b0;

  int              cyc_n = 0;
  int              m_ptr, m_flush, m_if;
  logic            m_err;
  tag_t            tagq [$];
  logic [NREQ-1:0] e_gnt, e_rsp_v;
  logic            e_den;
  vec_t            e_mx;
  logic [BW-1:0]   e_rsp_d;
  int              e_rsp_id;

  int glog [$];
  int gcyc [$];
  int rlog_id [$];
  int rlog_d [$];
  int rcyc [$];
  int peak;

  function automatic logic [BW-1:0] max5(vec_t v);
    logic [BW-1:0] m = '0;
    for (int k = 0; k < 5; k++)
      if (v[k*BW +: BW] > m) m = v[k*BW +: BW];
    return m;
  endfunction

  function automatic vec_t pack5(int a, int b, int c,
                                 int d, int e);
    return {BW'(e), BW'(d), BW'(c), BW'(b), BW'(a)};
  endfunction

  task automatic chk(string nm, longint act, longint want);
    total++;
    if (act != want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)",
               nm, act, want, cyc_n);
    end
  endtask

  task automatic drive_req();
    for (int i = 0; i < NREQ; i++) begin
      rq.req[i] = hd[i] < tl[i];
      if (hd[i] < tl[i])
        rq.req_data[i*5*BW +: 5*BW] = qbuf[i][hd[i] % DEP];
    end
  endtask

  task automatic push_vec(int i, vec_t v);
    if (tl[i] - hd[i] < DEP - 1) begin
      qbuf[i][tl[i] % DEP] = v;
      tl[i]++;
    end
  endtask

  // one clock: max_n5 stand-in, then requesters react to gnt
  task automatic step();
    @(posedge clk);
    #1;
    mx_den_out  = mxv[0] | spur;
    mx_data_max = mxm[0];
    spur = 1'b0;
    for (int k = 0; k < LAT - 1; k++) begin
      mxv[k] = mxv[k+1];
      mxm[k] = mxm[k+1];
    end
    mxv[LAT-1] = mx_den_in;
    mxm[LAT-1] = max5({mx_data4, mx_data3, mx_data2,
                       mx_data1, mx_data0});
    for (int i = 0; i < NREQ; i++)
      if (rq.gnt[i] && hd[i] < tl[i]) hd[i]++;
    drive_req();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    for (int i = 0; i < NREQ; i++) begin
      hd[i] = 0;
      tl[i] = 0;
    end
    drive_req();
    step();
    rst = 1'b0;
  endtask

  task automatic clear_logs();
    glog.delete();
    gcyc.delete();
    rlog_id.delete();
    rlog_d.delete();
    rcyc.delete();
    peak = 0;
  endtask

  function automatic void model_reset();
    m_ptr    = 0;
    m_flush  = LAT;
    m_if     = 0;
    m_err    = 1'b0;
    tagq.delete();
    e_gnt    = '0;
    e_rsp_v  = '0;
    e_den    = 1'b0;
    e_mx     = '0;
    e_rsp_d  = '0;
    e_rsp_id = 0;
  endfunction

  function automatic void model_next();
    bit live;
    bit tv;
    int id;
    tag_t t;
    live = (m_flush == 0);
    tv = tagq.size() > 0 && tagq[0].due == cyc_n;
    e_rsp_v = '0;
    if (live && mx_den_out && tv) begin
      e_rsp_v  = NREQ'(1) << tagq[0].id;
      e_rsp_d  = BW'(tagq[0].mx);
      e_rsp_id = tagq[0].id;
    end
    if (live && (mx_den_out != tv)) m_err = 1'b1;
    if (tv) begin
      void'(tagq.pop_front());
      m_if--;
    end
    e_gnt = '0;
    e_den = 1'b0;
    if (rq.en && live) begin
      for (int k = 0; k < NREQ; k++) begin
        id = (m_ptr + k) % NREQ;
        if (!e_den && hd[id] < tl[id]) begin
          e_den  = 1'b1;
          e_gnt  = NREQ'(1) << id;
          e_mx   = qbuf[id][hd[id] % DEP];
          t.id   = id;
          t.mx   = int'(max5(e_mx));
          t.due  = cyc_n + 1 + LAT;
          tagq.push_back(t);
          m_ptr  = (id + 1) % NREQ;
          m_if++;
        end
      end
    end
    if (m_flush > 0) m_flush--;
  endfunction

  always @(negedge clk) begin
    if (rst) model_reset();
    chk("gnt", rq.gnt, e_gnt);
    chk("mx_den_in", mx_den_in, e_den);
    if (e_den)
      chk("mx_data", {mx_data4, mx_data3, mx_data2,
                      mx_data1, mx_data0}, e_mx);
    chk("rsp_valid", rq.rsp_valid, e_rsp_v);
    chk("rsp_data", rq.rsp_data, e_rsp_d);
    chk("rsp_id", rq.rsp_id, e_rsp_id);
    chk("in_flight", in_flight, m_if);
    chk("err", err, m_err);
    for (int i = 0; i < NREQ; i++)
      if (rq.gnt[i]) begin
        glog.push_back(i);
        gcyc.push_back(cyc_n);
      end
    if (rq.rsp_valid != '0) begin
      rlog_id.push_back(int'(rq.rsp_id));
      rlog_d.push_back(int'(rq.rsp_data));
      rcyc.push_back(cyc_n);
    end
    if (int'(in_flight) > peak) peak = int'(in_flight);
    if (!rst) model_next();
    cyc_n++;
  end

  initial begin
    #200000;
    $display("watchdog timeout at cycle %0d", cyc_n);
    $fatal(1, "timeout");
  end

  initial begin
    int n_g, n_r, rel, w, cnt, fg;
    bit busy;
    rq.en = 1'b0;
    rq.req = '0;
    rq.req_data = '0;
    for (int k = 0; k < LAT; k++) begin
      mxv[k] = 1'b0;
      mxm[k] = '0;
    end
    for (int i = 0; i < NREQ; i++) begin
      hd[i] = 0;
      tl[i] = 0;
    end
    clear_logs();
    repeat (3) step();
    chk("reset gnt", rq.gnt, 0);
    chk("reset in_flight", in_flight, 0);
    chk("reset err", err, 0);
    rst = 1'b0;

    // single request
    rq.en = 1'b1;
    repeat (3) step();
    clear_logs();
    push_vec(0, pack5(3, 9, 1, 7, 2));
    drive_req();
    repeat (8) step();
    chk("t1 grants", glog.size(), 1);
    chk("t1 rsps", rlog_d.size(), 1);
    if (glog.size() == 1 && rlog_d.size() == 1) begin
      chk("t1 gnt id", glog[0], 0);
      chk("t1 rsp id", rlog_id[0], 0);
      chk("t1 rsp data", rlog_d[0], 9);
      chk("t1 latency", rcyc[0] - gcyc[0], 4);
    end

    // all four held
    do_reset();
    repeat (3) step();
    clear_logs();
    for (int i = 0; i < NREQ; i++)
      for (int j = 0; j < 2; j++)
        push_vec(i, vec_t'({$urandom, $urandom}));
    drive_req();
    repeat (16) step();
    chk("t2 grants", glog.size(), 8);
    for (int k = 0; k < glog.size() && k < 8; k++)
      chk("t2 rr order", glog[k], k % 4);
    for (int k = 0; k < rlog_id.size() && k < 4; k++)
      chk("t2 rsp order", rlog_id[k], k);
    chk("t2 peak in_flight", peak, 4);

    // back-to-back on one requester
    do_reset();
    repeat (3) step();
    clear_logs();
    push_vec(2, pack5(5, 5, 5, 5, 5));
    push_vec(2, pack5(0, 0, 0, 0, 255));
    for (int j = 0; j < 8; j++)
      push_vec(2, vec_t'({$urandom, $urandom}));
    drive_req();
    repeat (16) step();
    chk("t3 grants", glog.size(), 10);
    chk("t3 rsps", rlog_d.size(), 10);
    if (glog.size() == 10)
      chk("t3 gnt span", gcyc[9] - gcyc[0], 9);
    if (rlog_d.size() == 10) begin
      chk("t3 rsp span", rcyc[9] - rcyc[0], 9);
      chk("t3 all equal", rlog_d[0], 5);
      chk("t3 max on 4", rlog_d[1], 255);
    end

    // en low with requests pending
    do_reset();
    repeat (3) step();
    clear_logs();
    for (int i = 0; i < NREQ; i++)
      for (int j = 0; j < 3; j++)
        push_vec(i, vec_t'({$urandom, $urandom}));
    drive_req();
    repeat (3) step();
    rq.en = 1'b0;
    step();
    n_g = glog.size();
    n_r = rlog_d.size();
    repeat (4) step();
    chk("t4 no gnt", glog.size(), n_g);
    chk("t4 drained", rlog_d.size() - n_r, 3);
    rq.en = 1'b1;
    repeat (12) step();
    if (glog.size() > n_g)
      chk("t4 resume id", glog[n_g], 3);
    else
      chk("t4 resumed", glog.size(), n_g + 1);

    // reset with ops in flight
    do_reset();
    repeat (3) step();
    clear_logs();
    for (int i = 0; i < NREQ; i++)
      for (int j = 0; j < 6; j++)
        push_vec(i, vec_t'({$urandom, $urandom}));
    drive_req();
    repeat (5) step();
    chk("t5 pre in_flight", in_flight, 4);
    rst = 1'b1;
    n_g = glog.size();
    n_r = rlog_d.size();
    step();
    rst = 1'b0;
    rel = cyc_n;
    chk("t5 in_flight", in_flight, 0);
    repeat (12) step();
    cnt = 0;
    for (int k = n_r; k < rlog_d.size(); k++)
      if (rcyc[k] <= rel + LAT + 1) cnt++;
    chk("t5 stale rsp", cnt, 0);
    fg = -1;
    for (int k = n_g; k < glog.size(); k++)
      if (fg < 0 && gcyc[k] >= rel) fg = gcyc[k];
    chk("t5 first gnt late", fg >= rel + 3, 1);
    chk("t5 err", err, 0);

    // spurious den_out
    do_reset();
    repeat (LAT + 3) step();
    n_r = rlog_d.size();
    spur = 1'b1;
    step();
    step();
    chk("t6 err set", err, 1);
    repeat (3) step();
    chk("t6 err sticky", err, 1);
    chk("t6 no rsp", rlog_d.size(), n_r);
    do_reset();
    chk("t6 err cleared", err, 0);

    // random traffic
    repeat (LAT) step();
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NREQ; i++)
        if ($urandom_range(0, 3) == 0) begin
          if ($urandom_range(0, 4) == 0) begin
            w = int'($urandom_range(0, 255));
            push_vec(i, pack5(w, w, w, w, w));
          end else begin
            push_vec(i, vec_t'({$urandom, $urandom}));
          end
        end
      rq.en = $urandom_range(0, 9) != 0;
      drive_req();
      step();
    end
    rq.en = 1'b1;
    w = 0;
    busy = 1'b1;
    while (busy && w < 200) begin
      step();
      w++;
      busy = in_flight != 0;
      for (int i = 0; i < NREQ; i++)
        if (hd[i] < tl[i]) busy = 1'b1;
    end
    chk("drain bound", w < 200, 1);
    repeat (2) step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
